// File: rtl/lsu_wb_if.sv
// Wishbone data-port bundle between the LSU and the data-side bus fabric.
// Latency: none (wires only).
// Backpressure: the slave stretches a cycle by withholding ack/err.
// Ports: adr, dat_w, sel, we, stb, cyc (master->slave); dat_r, ack, err (slave->master).
interface wishbone #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0]   adr;
    logic [XLEN-1:0]   dat_w;
    logic [XLEN-1:0]   dat_r;
    logic [XLEN/8-1:0] sel;
    logic              we;
    logic              stb;
    logic              cyc;
    logic              ack;
    logic              err;

    modport MASTER (
        output adr, dat_w, sel, we, stb, cyc,
        input  dat_r, ack, err
    );

    modport SLAVE (
        input  adr, dat_w, sel, we, stb, cyc,
        output dat_r, ack, err
    );
endinterface

// File: rtl/lsu_wb.sv
// Load/store unit: decodes memory ops, runs one registered Wishbone cycle, aligns and extends data.
// Latency: 2 cycles to DONE with a zero-wait slave (+1 per wait state); 1 cycle for a faulting op.
// Backpressure: stalled holds upstream while busy; stall holds the result in DONE.
// Ports: clk, rst_n (sync, active-low); data_bus (Wishbone master); instr, ieu_result, ieu_rs2, stall in;
//        stalled, writeback_data, fault, fault_cause (00 none, 01 misaligned/illegal, 10 bus err, 11 timeout) out.
// Optional macro LSU_TIMEOUT_EN: bus watchdog that aborts REQ after TIMEOUT_CYCLES cycles with cause 11.
module lsu_wb #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    wishbone.MASTER         data_bus,
    input  logic [31:2]     instr,
    input  logic [XLEN-1:0] ieu_result,
    input  logic [XLEN-1:0] ieu_rs2,
    input  logic            stall,
    output logic            stalled,
    output logic [XLEN-1:0] writeback_data,
    output logic            fault,
    output logic [1:0]      fault_cause
);
    localparam int NB  = XLEN / 8;
    localparam int OFF = $clog2(NB);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t state, state_nxt;

    // Decode
    logic [4:0]     opcode;
    logic [2:0]     funct3;
    logic           is_load, is_store, memop;
    logic           illegal, misaligned, bad;
    logic [OFF-1:0] off;
    logic [NB-1:0]  sel_mask;
    logic           unused_instr;

    assign opcode   = instr[6:2];
    assign funct3   = instr[14:12];
    assign is_load  = (opcode == 5'b00000);
    assign is_store = (opcode == 5'b01000);
    assign memop    = is_load | is_store;
    assign off      = ieu_result[OFF-1:0];
    assign unused_instr = ^{instr[31:15], instr[11:7]};

    // Doubles and LWU only exist on a 64-bit datapath; stores have no unsigned form.
    assign illegal = ((XLEN == 32) && ((funct3[1:0] == 2'b11) || (funct3 == 3'b110)))
                   || (is_store && funct3[2]);
    assign bad     = illegal | misaligned;

    always_comb begin
        misaligned = 1'b0;
        sel_mask   = NB'(1);
        case (funct3[1:0])
            2'b01: begin misaligned = ieu_result[0];     sel_mask = NB'(3);   end
            2'b10: begin misaligned = |ieu_result[1:0];  sel_mask = NB'(15);  end
            2'b11: begin misaligned = |ieu_result[2:0];  sel_mask = NB'(255); end
            default: ;
        endcase
    end

    // Bus and result registers
    logic            bus_act;
    logic            we_q;
    logic [NB-1:0]   sel_q;
    logic [XLEN-1:0] adr_q, dat_w_q, wb_q;
    logic [2:0]      f3_q;
    logic [OFF-1:0]  off_q;
    logic            tmo_hit;

    assign data_bus.cyc   = bus_act;
    assign data_bus.stb   = bus_act;
    assign data_bus.we    = we_q;
    assign data_bus.sel   = sel_q;
    assign data_bus.adr   = adr_q;
    assign data_bus.dat_w = dat_w_q;

    // Load extraction: shift the addressed lane down, then mask to size and extend.
    logic [XLEN-1:0] shifted, ld_mask, ld_ext;
    logic            ld_sign;

    always_comb begin
        shifted = data_bus.dat_r >> {off_q, 3'b000};
        ld_mask = '1;
        ld_sign = 1'b0;
        case (f3_q[1:0])
            2'b00: begin ld_mask = XLEN'(64'hFF);        ld_sign = shifted[7];  end
            2'b01: begin ld_mask = XLEN'(64'hFFFF);      ld_sign = shifted[15]; end
            2'b10: begin ld_mask = XLEN'(64'hFFFF_FFFF); ld_sign = shifted[31]; end
            default: ;
        endcase
        ld_ext = (shifted & ld_mask) | ((ld_sign && !f3_q[2]) ? ~ld_mask : '0);
    end

`ifdef LSU_TIMEOUT_EN
    localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TW     = (TW_RAW < 8) ? 8 : ((TW_RAW > 16) ? 16 : TW_RAW);
    logic [TW-1:0] tmo_cnt;

    // Expires on the TIMEOUT_CYCLES-th REQ cycle without a response; ack/err still win.
    assign tmo_hit = (state == REQ) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || state != REQ)
            tmo_cnt <= '0;
        else if (!data_bus.ack && !data_bus.err)
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // FSM
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        stalled        = 1'b0;
        writeback_data = ieu_result;
        case (state)
            IDLE: begin
                stalled = memop;
                if (memop)
                    state_nxt = bad ? DONE : REQ;
            end
            REQ: begin
                stalled = 1'b1;
                if (data_bus.ack || data_bus.err || tmo_hit)
                    state_nxt = DONE;
            end
            DONE: begin
                writeback_data = wb_q;
                if (!stall)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus_act     <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_w_q     <= '0;
            wb_q        <= '0;
            f3_q        <= '0;
            off_q       <= '0;
            fault       <= 1'b0;
            fault_cause <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (memop && bad) begin
                        fault       <= 1'b1;
                        fault_cause <= 2'b01;
                        wb_q        <= '0;
                    end else if (memop) begin
                        bus_act <= 1'b1;
                        we_q    <= is_store;
                        sel_q   <= sel_mask << off;
                        adr_q   <= {ieu_result[XLEN-1:OFF], {OFF{1'b0}}};
                        dat_w_q <= ieu_rs2 << {off, 3'b000};
                        f3_q    <= funct3;
                        off_q   <= off;
                    end
                end
                REQ: begin
                    if (data_bus.ack || data_bus.err || tmo_hit) begin
                        bus_act <= 1'b0;
                        we_q    <= 1'b0;
                        sel_q   <= '0;
                    end
                    if (data_bus.err) begin
                        fault       <= 1'b1;
                        fault_cause <= 2'b10;
                        wb_q        <= '0;
                    end else if (data_bus.ack) begin
                        fault       <= 1'b0;
                        fault_cause <= 2'b00;
                        wb_q        <= we_q ? '0 : ld_ext;
                    end else if (tmo_hit) begin
                        fault       <= 1'b1;
                        fault_cause <= 2'b11;
                        wb_q        <= '0;
                    end
                end
                DONE: begin
                    if (!stall) begin
                        fault       <= 1'b0;
                        fault_cause <= 2'b00;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
